// File: rtl/read_header_func.sv
// Ethernet header receiver: stores dest/src MAC and EtherType into argument memories, then drains
// and counts the payload. Optional EtherType filter compiled in with READ_HEADER_TYPE_FILTER_EN.
module read_header_func #(
  parameter logic [15:0] TYPE_MATCH = 16'h0800,
  parameter int unsigned LEN_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [47:0]      arg_0_raddr,
  output logic [47:0]      arg_0_waddr,
  output logic [47:0]      arg_0_wdata,
  output logic             arg_0_wen,
  input  logic [47:0]      arg_0_rdata,
  output logic [47:0]      arg_1_raddr,
  output logic [47:0]      arg_1_waddr,
  output logic [47:0]      arg_1_wdata,
  output logic             arg_1_wen,
  input  logic [47:0]      arg_1_rdata,
  output logic [15:0]      arg_2_raddr,
  output logic [15:0]      arg_2_waddr,
  output logic [15:0]      arg_2_wdata,
  output logic             arg_2_wen,
  input  logic [15:0]      arg_2_rdata,
  input  logic             arg_3_m_eth_hdr_valid,
  output logic             arg_3_m_eth_hdr_ready,
  input  logic [47:0]      arg_3_m_eth_dest_mac,
  input  logic [47:0]      arg_3_m_eth_src_mac,
  input  logic [15:0]      arg_3_m_eth_type,
  input  logic [7:0]       arg_3_m_eth_payload_axis_tdata,
  input  logic             arg_3_m_eth_payload_axis_tvalid,
  input  logic             arg_3_m_eth_payload_axis_tlast,
  input  logic             arg_3_m_eth_payload_axis_tuser,
  output logic             arg_3_m_eth_payload_axis_tready,
  input  logic             arg_3_busy,
  output logic [LEN_W-1:0] payload_len,
  output logic             frame_err,
  output logic             valid
);

  typedef enum logic [2:0] {StIdle, StWrDest, StWrSrc, StWrType, StDrain, StDone} state_e;

  state_e            state_q;
  logic [47:0]       dest_q, src_q;
  logic [15:0]       type_q;
  logic [LEN_W-1:0]  cnt_q, len_q, cnt_inc;
  logic              hdr_ready_q, tready_q, valid_q, err_q;
  logic              wen0_q, wen1_q, wen2_q;
  logic              beat;
`ifdef READ_HEADER_TYPE_FILTER_EN
  logic              drop_q;
`endif

  assign beat    = arg_3_m_eth_payload_axis_tvalid & tready_q;
  assign cnt_inc = (cnt_q == {LEN_W{1'b1}}) ? cnt_q : cnt_q + LEN_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      dest_q      <= '0;
      src_q       <= '0;
      type_q      <= '0;
      cnt_q       <= '0;
      len_q       <= '0;
      err_q       <= 1'b0;
      hdr_ready_q <= 1'b0;
      tready_q    <= 1'b0;
      valid_q     <= 1'b0;
      wen0_q      <= 1'b0;
      wen1_q      <= 1'b0;
      wen2_q      <= 1'b0;
`ifdef READ_HEADER_TYPE_FILTER_EN
      drop_q      <= 1'b0;
`endif
    end else begin
      wen0_q  <= 1'b0;
      wen1_q  <= 1'b0;
      wen2_q  <= 1'b0;
      valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          hdr_ready_q <= 1'b1;
          if (arg_3_m_eth_hdr_valid && hdr_ready_q) begin
            dest_q      <= arg_3_m_eth_dest_mac;
            src_q       <= arg_3_m_eth_src_mac;
            type_q      <= arg_3_m_eth_type;
            cnt_q       <= '0;
            hdr_ready_q <= 1'b0;
`ifdef READ_HEADER_TYPE_FILTER_EN
            drop_q      <= (arg_3_m_eth_type != TYPE_MATCH);
            if (arg_3_m_eth_type != TYPE_MATCH) begin
              state_q  <= StDrain;
              tready_q <= 1'b1;
            end else begin
              state_q <= StWrDest;
              wen0_q  <= 1'b1;
            end
`else
            state_q <= StWrDest;
            wen0_q  <= 1'b1;
`endif
          end
        end
        StWrDest: begin
          state_q <= StWrSrc;
          wen1_q  <= 1'b1;
        end
        StWrSrc: begin
          state_q <= StWrType;
          wen2_q  <= 1'b1;
        end
        StWrType: begin
          state_q  <= StDrain;
          tready_q <= 1'b1;
        end
        StDrain: begin
          if (beat) begin
            cnt_q <= cnt_inc;
            if (arg_3_m_eth_payload_axis_tlast) begin
              tready_q <= 1'b0;
`ifdef READ_HEADER_TYPE_FILTER_EN
              if (drop_q) begin
                // Filtered frame: back to idle silently, reported fields untouched.
                state_q     <= StIdle;
                hdr_ready_q <= 1'b1;
              end else begin
                state_q <= StDone;
                valid_q <= 1'b1;
                len_q   <= cnt_inc;
                err_q   <= arg_3_m_eth_payload_axis_tuser;
              end
`else
              state_q <= StDone;
              valid_q <= 1'b1;
              len_q   <= cnt_inc;
              err_q   <= arg_3_m_eth_payload_axis_tuser;
`endif
            end
          end
        end
        StDone: begin
          state_q     <= StIdle;
          hdr_ready_q <= 1'b1;
        end
        default: begin
          state_q     <= StIdle;
          hdr_ready_q <= 1'b0;
          tready_q    <= 1'b0;
        end
      endcase
    end
  end

  assign arg_0_raddr = '0;
  assign arg_0_waddr = '0;
  assign arg_1_raddr = '0;
  assign arg_1_waddr = '0;
  assign arg_2_raddr = '0;
  assign arg_2_waddr = '0;
  assign arg_0_wdata = dest_q;
  assign arg_1_wdata = src_q;
  assign arg_2_wdata = type_q;
  assign arg_0_wen   = wen0_q;
  assign arg_1_wen   = wen1_q;
  assign arg_2_wen   = wen2_q;

  assign arg_3_m_eth_hdr_ready           = hdr_ready_q;
  assign arg_3_m_eth_payload_axis_tready = tready_q;
  assign payload_len = len_q;
  assign frame_err   = err_q;
  assign valid       = valid_q;

  logic unused_inputs;
`ifdef READ_HEADER_TYPE_FILTER_EN
  assign unused_inputs = ^{arg_0_rdata, arg_1_rdata, arg_2_rdata, arg_3_busy,
                           arg_3_m_eth_payload_axis_tdata};
`else
  assign unused_inputs = ^{arg_0_rdata, arg_1_rdata, arg_2_rdata, arg_3_busy,
                           arg_3_m_eth_payload_axis_tdata, TYPE_MATCH};
`endif

endmodule

// File: doc/read_header_func.md
# read_header_func

Receive-side counterpart of the Ethernet header writer. It accepts one Ethernet header from an `eth_axis_rx` master port and stores the destination MAC, source MAC and EtherType into three single-word argument memories. It then drains and counts the frame payload, and pulses `valid` once per completed frame. It sits between `eth_axis_rx` and HLS-generated consumers that read header fields from argument memories.

## Interface
Parameters:
- `TYPE_MATCH`, default 16'h0800: EtherType accepted when the filter is compiled in.
- `LEN_W`, default 16: width of the payload byte counter.

Ports:
- `clk` in 1: single clock; all logic is on its rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `arg_0_raddr`, `arg_0_waddr` out 48: dest MAC memory addresses; always 0.
- `arg_0_wdata` out 48: dest MAC write data.
- `arg_0_wen` out 1: dest MAC write enable.
- `arg_0_rdata` in 48: unused.
- `arg_1_raddr`, `arg_1_waddr` out 48: src MAC memory addresses; always 0.
- `arg_1_wdata` out 48: src MAC write data.
- `arg_1_wen` out 1: src MAC write enable.
- `arg_1_rdata` in 48: unused.
- `arg_2_raddr`, `arg_2_waddr` out 16: EtherType memory addresses; always 0.
- `arg_2_wdata` out 16: EtherType write data.
- `arg_2_wen` out 1: EtherType write enable.
- `arg_2_rdata` in 16: unused.
- `arg_3_m_eth_hdr_valid` in 1: header valid from `eth_axis_rx`.
- `arg_3_m_eth_hdr_ready` out 1: header ready to `eth_axis_rx`.
- `arg_3_m_eth_dest_mac` in 48: header field.
- `arg_3_m_eth_src_mac` in 48: header field.
- `arg_3_m_eth_type` in 16: header field.
- `arg_3_m_eth_payload_axis_tdata` in 8: payload byte.
- `arg_3_m_eth_payload_axis_tvalid` in 1: payload beat valid.
- `arg_3_m_eth_payload_axis_tlast` in 1: last payload beat.
- `arg_3_m_eth_payload_axis_tuser` in 1: frame error, sampled on the last beat.
- `arg_3_m_eth_payload_axis_tready` out 1: payload ready.
- `arg_3_busy` in 1: unused.
- `payload_len` out LEN_W: byte count of the last completed frame.
- `frame_err` out 1: `tuser` value captured on the last beat of the last completed frame.
- `valid` out 1: one-cycle pulse when a frame completes.

## Operation
- FSM states: IDLE, WR_DEST, WR_SRC, WR_TYPE, DRAIN, DONE.
- IDLE:
  - `hdr_ready`=1.
  - On `hdr_valid && hdr_ready`, capture the three fields into internal registers and go to WR_DEST.
- WR_DEST / WR_SRC / WR_TYPE:
  - Each state lasts exactly one cycle.
  - In that cycle the matching `arg_N_wen`=1 and `arg_N_wdata` is the captured field.
  - All other `wen` are 0.
- DRAIN:
  - `tready`=1. The byte counter clears on header accept.
  - Each `tvalid && tready` beat increments the counter, saturating at 2^LEN_W-1.
  - A beat with `tlast`=1 moves the FSM to DONE. On that beat, `payload_len` ← counter+1 (saturated) and `frame_err` ← `tuser`.
- DONE: `valid`=1 for one cycle, then return to IDLE.
- Address outputs (`arg_N_raddr`, `arg_N_waddr`) are constant 0. `tdata` is ignored.
- A `tlast` beat arriving in the first DRAIN cycle is legal. That gives `payload_len`=1.

## Timing
- Reset (`rst_n`=0):
  - FSM → IDLE.
  - All outputs are 0, including `hdr_ready`, `tready`, `valid`, `payload_len` and `frame_err`.
  - The captured-field registers clear to 0.
- `hdr_ready` rises on the first `clk` edge after `rst_n` deasserts.
- Latency from header accept edge: WR_DEST +1, WR_SRC +2, WR_TYPE +3, DRAIN entered +4. `valid` follows the `tlast` beat by 1 cycle.
- `hdr_ready`=0 in every state except IDLE. `tready`=0 in every state except DRAIN.
- Payload beats are never accepted before the three memory writes finish.
- If `hdr_valid` is held through DONE, the next header is accepted on the first IDLE cycle after it. There is no accept during DONE.
- If `rst_n` is asserted mid-frame, the partial frame is abandoned: no `valid`, no write, and `payload_len` resets to 0.

## Configuration
- `READ_HEADER_TYPE_FILTER_EN` defined: the filter is compiled in.
  - If the captured type ≠ `TYPE_MATCH`, the FSM skips WR_DEST, WR_SRC and WR_TYPE and enters DRAIN on the next cycle.
  - The payload is drained, but there is no `valid` pulse, and `payload_len` and `frame_err` are not updated. The FSM returns directly to IDLE after `tlast`.
- `READ_HEADER_TYPE_FILTER_EN` undefined: every header is written and reported as described in Operation. `TYPE_MATCH` is unused.

## Test plan
- Reset, then release → `hdr_ready`=1 one edge later. All other outputs stay 0 until a header arrives.
- Header dest=0x112233445566, src=0xAABBCCDDEEFF, type=0x0800, then 4-byte payload with `tlast` on byte 4 → `arg_0`/`arg_1`/`arg_2` `wen` pulse on cycles +1/+2/+3 with those values, `payload_len`=4, `frame_err`=0, one `valid` pulse.
- 1-byte payload with `tlast`=1 and `tuser`=1 → `payload_len`=1, `frame_err`=1.
- `tvalid` toggling 1,0,1,0 over 3 beats with `tlast` on the 3rd → `payload_len`=3. `tready` stays 1 throughout DRAIN.
- `rst_n` pulsed low after 2 payload bytes → all outputs 0 immediately, and no `valid`. The next frame of 5 bytes gives `payload_len`=5.
- With `READ_HEADER_TYPE_FILTER_EN`, type=0x86DD and 3 bytes → no `wen`, no `valid`, `payload_len` unchanged. A following frame with type=0x0800 is handled normally.
